data_mem_responder: RTL

//  Data-memory end of the core's data bus: services the per-cycle read/write strobes, address and store data.

---
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data-memory end of the core's data bus. Writes are posted
//               into a circular write buffer and drained into a single-port
//               RAM during idle cycles, or forced out when a write arrives
//               with the buffer full. Reads forward the youngest matching
//               buffered write, otherwise read RAM, and return data after
//               READ_LAT clock edges. The core never stalls.
// Ports       : clk, rst (async, active-high)
//               read, write, address[AW], data_in[DW]   - core request
//               data_out[DW], rvalid                     - load response
//               wb_count, wb_full                        - buffer occupancy
//               err                                      - sticky read+write
//               rd_cnt[16], wr_cnt[16]                   - only with DMEM_STATS_EN
// Options     : `define DMEM_STATS_EN adds saturating read/write counters.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int WB_DEPTH = 4,
  parameter int READ_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        read,
  input  logic                        write,
  input  logic [AW-1:0]               address,
  input  logic [DW-1:0]               data_in,
  output logic [DW-1:0]               data_out,
  output logic                        rvalid,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_full,
`ifdef DMEM_STATS_EN
  output logic [15:0]                 rd_cnt,
  output logic [15:0]                 wr_cnt,
`endif
  output logic                        err
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  // Write buffer storage (contents need no reset: validity comes from the count)
  logic [AW-1:0] wb_addr_q [WB_DEPTH];
  logic [DW-1:0] wb_data_q [WB_DEPTH];
  logic [DW-1:0] mem_q     [1<<AW];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] wb_count_q, wb_count_d;
  logic          err_q;
  logic          s1_valid_q;
  logic [DW-1:0] s1_data_q;

  logic          push, pop, full;
  logic [DW-1:0] rd_data_d;
  logic [PW-1:0] idx;

  assign full = (wb_count_q == CW'(WB_DEPTH));
  // A simultaneous read+write drops the write; reads own the RAM port.
  assign push = write & ~read;
  // Drain when idle, or make room when a write lands on a full buffer.
  assign pop  = (wb_count_q != '0) & ~read & (~write | full);

  assign wb_count_d = wb_count_q + CW'(push) - CW'(pop);

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    rd_data_d = mem_q[address];
    idx       = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < wb_count_q) && (wb_addr_q[idx] == address))
        rd_data_d = wb_data_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= address;
      wb_data_q[wr_ptr_q] <= data_in;
    end
    if (pop)
      mem_q[wb_addr_q[rd_ptr_q]] <= wb_data_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wb_count_q <= '0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      wb_count_q <= wb_count_d;
      if (read & write) err_q <= 1'b1;
      s1_valid_q <= read;
      if (read) s1_data_q <= rd_data_d;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic          s2_valid_q;
      logic [DW-1:0] s2_data_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) s2_data_q <= s1_data_q;
        end
      end
      assign rvalid   = s2_valid_q;
      assign data_out = s2_data_q;
    end else begin : g_lat1
      assign rvalid   = s1_valid_q;
      assign data_out = s1_data_q;
    end
  endgenerate

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (read && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (push && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

  assign wb_count = wb_count_q;
  assign wb_full  = full;
  assign err      = err_q;

endmodule
`default_nettype wire
